// File: rtl/para_report_tx.sv
// Parameter read-back transmitter: snapshots the six acquisition parameters on a
// request and streams them as a 30-byte framed packet to the shared UART.
module para_report_tx #(
  parameter logic [7:0] START_CODE = 8'hAA,
  parameter logic [7:0] END_CODE   = 8'h55,
  parameter int         TX_TIMEOUT = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        report_req,
  input  logic [7:0]  ctrl_code,
  input  logic [31:0] travelling_wave_collect_freq,
  input  logic [15:0] travelling_wave_collect_duration,
  input  logic [15:0] travelling_wave_alarm_threshold,
  input  logic [31:0] power_frequency_collect_freq,
  input  logic [15:0] power_frequency_collect_duration,
  input  logic [15:0] power_frequency_alarm_threshold,
  input  logic        tx_idle,
  output logic [7:0]  tx_data,
  output logic        start_tx,
  output logic        module_run_flag,
  output logic        report_done,
  output logic        report_err,
  output logic [2:0]  dbg_state
);

  // UART handshake: start_tx is a one-cycle strobe with tx_data valid in that
  // cycle; the UART acknowledges the byte with a falling edge on tx_idle, and no
  // further strobe is issued until that acknowledge has been seen.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SEND  = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4,
    S_ABORT = 3'd5
  } state_t;

  localparam int            CW       = $clog2(TX_TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TX_TIMEOUT - 1);

  state_t        state_q, state_d;
  logic          req1_q, req2_q, idle1_q, idle2_q;
  logic [4:0]    idx_q, idx_d;
  logic [7:0]    sum_q, sum_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic [7:0]    ctrl_q, ctrl_d;
  logic [31:0]   twf_q, twf_d, pff_q, pff_d;
  logic [15:0]   twd_q, twd_d, twt_q, twt_d, pfd_q, pfd_d, pft_q, pft_d;
  logic          req_rise, tx_done, load_byte;
  logic [7:0]    frame_byte;

  assign req_rise = req1_q & ~req2_q;
  assign tx_done  = idle2_q & ~idle1_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req1_q    <= 1'b1;
      req2_q    <= 1'b1;
      idle1_q   <= 1'b1;
      idle2_q   <= 1'b1;
      state_q   <= S_IDLE;
      idx_q     <= 5'd0;
      sum_q     <= 8'h00;
      cnt_q     <= '0;
      tx_data_q <= 8'h00;
      ctrl_q    <= 8'h00;
      twf_q     <= 32'h0;
      twd_q     <= 16'h0;
      twt_q     <= 16'h0;
      pff_q     <= 32'h0;
      pfd_q     <= 16'h0;
      pft_q     <= 16'h0;
    end else begin
      req1_q    <= report_req;
      req2_q    <= req1_q;
      idle1_q   <= tx_idle;
      idle2_q   <= idle1_q;
      state_q   <= state_d;
      idx_q     <= idx_d;
      sum_q     <= sum_d;
      cnt_q     <= cnt_d;
      tx_data_q <= tx_data_d;
      ctrl_q    <= ctrl_d;
      twf_q     <= twf_d;
      twd_q     <= twd_d;
      twt_q     <= twt_d;
      pff_q     <= pff_d;
      pfd_q     <= pfd_d;
      pft_q     <= pft_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    sum_d      = sum_q;
    cnt_d      = cnt_q;
    tx_data_d  = tx_data_q;
    ctrl_d     = ctrl_q;
    twf_d      = twf_q;
    twd_d      = twd_q;
    twt_d      = twt_q;
    pff_d      = pff_q;
    pfd_d      = pfd_q;
    pft_d      = pft_q;
    load_byte  = 1'b0;
    frame_byte = 8'h00;

    case (state_q)
      S_IDLE: begin
        if (req_rise) state_d = S_LOAD;
      end
      S_LOAD: begin
        ctrl_d    = ctrl_code;
        twf_d     = travelling_wave_collect_freq;
        twd_d     = travelling_wave_collect_duration;
        twt_d     = travelling_wave_alarm_threshold;
        pff_d     = power_frequency_collect_freq;
        pfd_d     = power_frequency_collect_duration;
        pft_d     = power_frequency_alarm_threshold;
        sum_d     = 8'h00;
        idx_d     = 5'd0;
        load_byte = 1'b1;
        state_d   = S_SEND;
      end
      S_SEND: begin
        // The strobe cycle itself is the first cycle of the timeout window.
        cnt_d   = CW'(1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (tx_done) begin
          if (idx_q < 5'd29) begin
            idx_d     = idx_q + 5'd1;
            load_byte = 1'b1;
            state_d   = S_SEND;
          end else begin
            state_d = S_DONE;
          end
        end else if (cnt_q == TMO_LAST) begin
          state_d = S_ABORT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ABORT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // tx_data is loaded on entry to SEND so it is stable during the strobe.
    if (load_byte) begin
      case (idx_d)
        5'd0:    frame_byte = START_CODE;
        5'd1:    frame_byte = ctrl_q;
        5'd2:    frame_byte = 8'h18;
        5'd4:    frame_byte = twf_q[7:0];
        5'd5:    frame_byte = twf_q[15:8];
        5'd6:    frame_byte = twf_q[23:16];
        5'd7:    frame_byte = twf_q[31:24];
        5'd8:    frame_byte = twd_q[7:0];
        5'd9:    frame_byte = twd_q[15:8];
        5'd12:   frame_byte = twt_q[7:0];
        5'd13:   frame_byte = twt_q[15:8];
        5'd16:   frame_byte = pff_q[7:0];
        5'd17:   frame_byte = pff_q[15:8];
        5'd18:   frame_byte = pff_q[23:16];
        5'd19:   frame_byte = pff_q[31:24];
        5'd20:   frame_byte = pfd_q[7:0];
        5'd21:   frame_byte = pfd_q[15:8];
        5'd24:   frame_byte = pft_q[7:0];
        5'd25:   frame_byte = pft_q[15:8];
        5'd28:   frame_byte = ~sum_q;
        5'd29:   frame_byte = END_CODE;
        default: frame_byte = 8'h00;
      endcase
      tx_data_d = frame_byte;
      if (idx_d != 5'd0 && idx_d <= 5'd27) sum_d = sum_d + frame_byte;
    end
  end

  assign tx_data         = tx_data_q;
  assign start_tx        = (state_q == S_SEND);
  assign module_run_flag = (state_q != S_IDLE);
  assign report_done     = (state_q == S_DONE);
  assign report_err      = (state_q == S_ABORT);
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_para_report_tx.sv
// Directed bench for para_report_tx: a frame-level model fills an expected byte
// queue, a monitor checks every strobed byte, and directed checks pin the model.
module tb_para_report_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        report_req;
  logic [7:0]  ctrl_code;
  logic [31:0] twf, pff;
  logic [15:0] twd, twt, pfd, pft;
  logic        tx_idle;
  logic [7:0]  tx_data;
  logic        start_tx, module_run_flag, report_done, report_err;
  logic [2:0]  dbg_state;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_start = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int err_cyc = 0;
  int uart_cnt = 0;
  int uart_limit = 1000000;
  logic [7:0] exp_q[$];
  logic [7:0] got_all[512];
  int         start_cyc[512];

  para_report_tx #(.START_CODE(8'hAA), .END_CODE(8'h55), .TX_TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .report_req(report_req), .ctrl_code(ctrl_code),
    .travelling_wave_collect_freq(twf), .travelling_wave_collect_duration(twd),
    .travelling_wave_alarm_threshold(twt), .power_frequency_collect_freq(pff),
    .power_frequency_collect_duration(pfd), .power_frequency_alarm_threshold(pft),
    .tx_idle(tx_idle), .tx_data(tx_data), .start_tx(start_tx),
    .module_run_flag(module_run_flag), .report_done(report_done),
    .report_err(report_err), .dbg_state(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // frame model: byte list built from field layout, checksum by plain arithmetic
  task automatic push_frame(input logic [7:0] c, input logic [31:0] a, input logic [15:0] b,
                            input logic [15:0] t, input logic [31:0] p, input logic [15:0] d,
                            input logic [15:0] h);
    logic [7:0] f[30];
    int s;
    for (int i = 0; i < 30; i++) f[i] = 8'h00;
    f[0] = 8'hAA; f[1] = c; f[2] = 8'h18;
    for (int i = 0; i < 4; i++) begin
      f[4 + i]  = 8'((a >> (8 * i)) & 32'hFF);
      f[16 + i] = 8'((p >> (8 * i)) & 32'hFF);
    end
    f[8] = b[7:0];   f[9] = b[15:8];
    f[12] = t[7:0];  f[13] = t[15:8];
    f[20] = d[7:0];  f[21] = d[15:8];
    f[24] = h[7:0];  f[25] = h[15:8];
    s = 0;
    for (int i = 1; i <= 27; i++) s = s + int'(f[i]);
    f[28] = ~8'(s % 256);
    f[29] = 8'h55;
    for (int i = 0; i < 30; i++) exp_q.push_back(f[i]);
  endtask

  task automatic set_params(input logic [7:0] c, input logic [31:0] a, input logic [15:0] b,
                            input logic [15:0] t, input logic [31:0] p, input logic [15:0] d,
                            input logic [15:0] h);
    ctrl_code = c; twf = a; twd = b; twt = t; pff = p; pfd = d; pft = h;
  endtask

  task automatic request();
    @(posedge clk); #1 report_req = 1'b1;
    repeat (3) @(posedge clk);
    #1 report_req = 1'b0;
  endtask

  task automatic wait_end(input int d0, input int e0);
    int k;
    k = 0;
    while (done_cnt == d0 && err_cnt == e0 && k < 3000) begin
      @(posedge clk);
      k++;
    end
    if (k >= 3000) begin
      total++; bad++;
      $display("FAIL frame_end_timeout: got=no_end expected=done_or_err");
    end
  endtask

  task automatic wait_starts(input int target);
    int k;
    k = 0;
    while (n_start < target && k < 3000) begin
      @(posedge clk);
      k++;
    end
    if (k >= 3000) begin
      total++; bad++;
      $display("FAIL start_wait_timeout: got=%0d expected=%0d", n_start, target);
    end
  endtask

  // UART model: drops tx_idle 50 cycles after each strobe it chooses to answer
  initial begin
    tx_idle = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst && start_tx) begin
        uart_cnt++;
        if (uart_cnt <= uart_limit) begin
          repeat (50) @(posedge clk);
          #1 tx_idle = 1'b0;
          repeat (2) @(posedge clk);
          #1 tx_idle = 1'b1;
        end
      end
    end
  end

  // scoreboard monitor
  initial begin
    logic [7:0] eb;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        if (start_tx) begin
          n_start++;
          if (n_start < 512) begin
            got_all[n_start] = tx_data;
            start_cyc[n_start] = cyc;
          end
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_start_tx: got=%0h expected=no_strobe", tx_data);
          end else begin
            eb = exp_q.pop_front();
            check("tx_byte", {24'h0, tx_data}, {24'h0, eb});
          end
        end
        if (report_done) begin
          done_cnt++;
          check("bytes_left_at_done", exp_q.size(), 0);
        end
        if (report_err) begin
          err_cnt++;
          err_cyc = cyc;
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, d0, e0, mark;
    rst = 1'b1;
    report_req = 1'b0;
    set_params(8'h00, 32'h0, 16'h0, 16'h0, 32'h0, 16'h0, 16'h0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_data", {24'h0, tx_data}, 32'h0);
    check("rst_start_tx", {31'h0, start_tx}, 32'h0);
    check("rst_run_flag", {31'h0, module_run_flag}, 32'h0);
    check("rst_done", {31'h0, report_done}, 32'h0);
    check("rst_err", {31'h0, report_err}, 32'h0);
    rst = 1'b0;
    repeat (5) @(posedge clk);

    // nominal frame
    set_params(8'h21, 32'h01020304, 16'h0506, 16'h0708, 32'h090A0B0C, 16'h0D0E, 16'h0F10);
    push_frame(8'h21, 32'h01020304, 16'h0506, 16'h0708, 32'h090A0B0C, 16'h0D0E, 16'h0F10);
    n0 = n_start; d0 = done_cnt; e0 = err_cnt;
    request();
    wait_end(d0, e0);
    check("nom_done_count", done_cnt - d0, 1);
    check("nom_byte_count", n_start - n0, 30);
    check("nom_byte0", {24'h0, got_all[n0 + 1]}, 32'hAA);
    check("nom_byte1", {24'h0, got_all[n0 + 2]}, 32'h21);
    check("nom_byte4", {24'h0, got_all[n0 + 5]}, 32'h04);
    check("nom_byte19", {24'h0, got_all[n0 + 20]}, 32'h09);
    // 0x21 + 0x18 + 0x88 = 0xC1, inverted
    check("nom_checksum", {24'h0, got_all[n0 + 29]}, 32'h3E);
    check("nom_end", {24'h0, got_all[n0 + 30]}, 32'h55);
    @(negedge clk);
    check("nom_run_flag_after", {31'h0, module_run_flag}, 32'h0);

    // snapshot: inputs change after the first strobe
    repeat (10) @(posedge clk);
    push_frame(8'h21, 32'h01020304, 16'h0506, 16'h0708, 32'h090A0B0C, 16'h0D0E, 16'h0F10);
    n0 = n_start; d0 = done_cnt; e0 = err_cnt;
    request();
    wait_starts(n0 + 1);
    set_params(8'hFF, 32'hFFFFFFFF, 16'hFFFF, 16'hFFFF, 32'hFFFFFFFF, 16'hFFFF, 16'hFFFF);
    wait_end(d0, e0);
    check("snap_byte_count", n_start - n0, 30);
    check("snap_checksum", {24'h0, got_all[n0 + 29]}, 32'h3E);

    // request while busy
    repeat (10) @(posedge clk);
    set_params(8'h21, 32'h01020304, 16'h0506, 16'h0708, 32'h090A0B0C, 16'h0D0E, 16'h0F10);
    push_frame(8'h21, 32'h01020304, 16'h0506, 16'h0708, 32'h090A0B0C, 16'h0D0E, 16'h0F10);
    n0 = n_start; d0 = done_cnt; e0 = err_cnt;
    request();
    wait_starts(n0 + 10);
    request();
    wait_end(d0, e0);
    repeat (200) @(posedge clk);
    check("busy_byte_count", n_start - n0, 30);
    check("busy_done_count", done_cnt - d0, 1);

    // timeout after byte 5
    uart_limit = uart_cnt + 5;
    push_frame(8'h21, 32'h01020304, 16'h0506, 16'h0708, 32'h090A0B0C, 16'h0D0E, 16'h0F10);
    n0 = n_start; d0 = done_cnt; e0 = err_cnt;
    request();
    wait_end(d0, e0);
    check("tmo_err_count", err_cnt - e0, 1);
    check("tmo_done_count", done_cnt - d0, 0);
    check("tmo_byte_count", n_start - n0, 6);
    check("tmo_latency", err_cyc - start_cyc[n0 + 6], 64);
    exp_q.delete();
    @(negedge clk);
    check("tmo_run_flag_after", {31'h0, module_run_flag}, 32'h0);
    uart_limit = 1000000;
    repeat (20) @(posedge clk);
    push_frame(8'h21, 32'h01020304, 16'h0506, 16'h0708, 32'h090A0B0C, 16'h0D0E, 16'h0F10);
    n0 = n_start; d0 = done_cnt; e0 = err_cnt;
    request();
    wait_end(d0, e0);
    check("tmo_retry_byte_count", n_start - n0, 30);
    check("tmo_retry_done", done_cnt - d0, 1);

    // asynchronous reset mid-frame
    repeat (10) @(posedge clk);
    push_frame(8'h21, 32'h01020304, 16'h0506, 16'h0708, 32'h090A0B0C, 16'h0D0E, 16'h0F10);
    n0 = n_start;
    request();
    wait_starts(n0 + 15);
    repeat (7) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("mid_rst_tx_data", {24'h0, tx_data}, 32'h0);
    check("mid_rst_start_tx", {31'h0, start_tx}, 32'h0);
    check("mid_rst_run_flag", {31'h0, module_run_flag}, 32'h0);
    check("mid_rst_done", {31'h0, report_done}, 32'h0);
    check("mid_rst_err", {31'h0, report_err}, 32'h0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    mark = n_start;
    repeat (100) @(posedge clk);
    check("post_rst_no_strobe", n_start - mark, 0);
    push_frame(8'h21, 32'h01020304, 16'h0506, 16'h0708, 32'h090A0B0C, 16'h0D0E, 16'h0F10);
    n0 = n_start; d0 = done_cnt; e0 = err_cnt;
    request();
    wait_end(d0, e0);
    check("post_rst_first_byte", {24'h0, got_all[n0 + 1]}, 32'hAA);
    check("post_rst_byte_count", n_start - n0, 30);

    // checksum wrap
    repeat (10) @(posedge clk);
    set_params(8'hFF, 32'hFFFFFFFF, 16'hFFFF, 16'hFFFF, 32'hFFFFFFFF, 16'hFFFF, 16'hFFFF);
    push_frame(8'hFF, 32'hFFFFFFFF, 16'hFFFF, 16'hFFFF, 32'hFFFFFFFF, 16'hFFFF, 16'hFFFF);
    n0 = n_start; d0 = done_cnt; e0 = err_cnt;
    request();
    wait_end(d0, e0);
    check("wrap_checksum", {24'h0, got_all[n0 + 29]}, 32'hF8);
    check("wrap_byte_count", n_start - n0, 30);
    check("wrap_queue_empty", exp_q.size(), 0);

    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
